acd_sweep: RTL and testbench

ACD_SWEEP -- requirements
Module: acd_sweep

---
 rtl/acd_sweep_defs.sv | 23 ++
 rtl/dwell_timer.sv | 30 +++
 rtl/acd_sweep.sv | 108 ++++++++++
 tb/tb_acd_sweep.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/acd_sweep_defs.sv
// rtl/acd_sweep_defs.sv - shared state encoding and sizing constants for acd_sweep
package acd_sweep_defs;

  localparam int DWELL_DEFAULT = 100;
  localparam int IDX_W         = 3;
  localparam int CNT_W         = 16;

  localparam logic [IDX_W-1:0] LAST_IDX = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Counter value on the last DRIVE cycle of a dwell period
  function automatic logic [CNT_W-1:0] dwell_tc_value(input int dwell);
    return CNT_W'(dwell - 1);
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - 16-bit dwell counter with load, enable and terminal count
module dwell_timer
  import acd_sweep_defs::*;
#(
  parameter int DWELL = DWELL_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count;

  // Clear on load (each DRIVE entry), otherwise count enabled cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // Terminal count marks the DWELL-th enabled cycle since the last load
  assign tc = en && (count == dwell_tc_value(DWELL));

endmodule

// File: rtl/acd_sweep.sv
// rtl/acd_sweep.sv - exhaustive 3-input sweep capturing two truth tables
module acd_sweep
  import acd_sweep_defs::*;
#(
  parameter int DWELL = DWELL_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       step_mode,
  input  logic       step,
  output logic       A,
  output logic       C,
  output logic       D,
  input  logic       F1,
  input  logic       F2,
  output logic [7:0] tt_f1,
  output logic [7:0] tt_f2,
  output logic       busy,
  output logic       done
);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             drive_entry;
  logic             dwell_tc;

  // Any transition into DRIVE restarts the dwell period
  always_comb begin
    drive_entry = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: drive_entry = start;
      ST_SAMPLE:        drive_entry = (idx != LAST_IDX) && !step_mode;
      ST_WAIT:          drive_entry = step;
      default:          drive_entry = 1'b0;
    endcase
  end

  dwell_timer #(
    .DWELL(DWELL)
  ) u_dwell_timer (
    .clk (clk),
    .rst (rst),
    .load(drive_entry),
    .en  (state == ST_DRIVE),
    .tc  (dwell_tc)
  );

  // Sweep sequencer: drive idx, dwell, sample results, advance or pause
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      tt_f1 <= 8'h00;
      tt_f2 <= 8'h00;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            idx   <= '0;
            tt_f1 <= 8'h00;
            tt_f2 <= 8'h00;
            done  <= 1'b0;
            busy  <= 1'b1;
            state <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (dwell_tc) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          tt_f1[idx] <= F1;
          tt_f2[idx] <= F2;
          if (idx == LAST_IDX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (!step_mode) begin
            idx   <= idx + 1'b1;
            state <= ST_DRIVE;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (step) begin
            idx   <= idx + 1'b1;
            state <= ST_DRIVE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign A = idx[0];
  assign C = idx[1];
  assign D = idx[2];

endmodule

// File: tb/tb_acd_sweep.sv
// tb/tb_acd_sweep.sv - scoreboard bench for acd_sweep
module tb_acd_sweep;

  localparam int D4 = 4;
  localparam int D2 = 2;

  typedef struct {
    logic [7:0] t1;
    logic [7:0] t2;
    int         cyc;
    bit         chk_lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  logic       start4 = 1'b0, step4 = 1'b0, step_mode4 = 1'b0;
  logic       a4, c4, d4, f1_4, f2_4, busy4, done4, done4_q = 1'b0;
  logic [7:0] tt1_4, tt2_4;

  logic       start2 = 1'b0, step2 = 1'b0, step_mode2 = 1'b1;
  logic       a2, c2, d2, f1_2, f2_2, busy2, done2, done2_q = 1'b0;
  logic [7:0] tt1_2, tt2_2;

  exp_t q4[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream logic stage model: F1 = A & C, F2 = C ^ D
  assign f1_4 = a4 & c4;
  assign f2_4 = c4 ^ d4;
  assign f1_2 = a2 & c2;
  assign f2_2 = c2 ^ d2;

  acd_sweep #(.DWELL(D4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .step_mode(step_mode4), .step(step4),
    .A(a4), .C(c4), .D(d4), .F1(f1_4), .F2(f2_4),
    .tt_f1(tt1_4), .tt_f2(tt2_4), .busy(busy4), .done(done4)
  );

  acd_sweep #(.DWELL(D2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .step_mode(step_mode2), .step(step2),
    .A(a2), .C(c2), .D(d2), .F1(f1_2), .F2(f2_2),
    .tt_f1(tt1_2), .tt_f2(tt2_2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the DWELL=4 instance: each rising done retires one expected sweep
  always @(negedge clk) begin
    if (done4 && !done4_q) begin
      if (q4.size() == 0) begin
        chk("dut4_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("dut4_tt_f1", {24'd0, tt1_4}, {24'd0, e.t1});
        chk("dut4_tt_f2", {24'd0, tt2_4}, {24'd0, e.t2});
        if (e.chk_lat) chk("dut4_latency", cyc, e.cyc);
      end
    end
    done4_q <= done4;
  end

  // Monitor for the DWELL=2 step-mode instance
  always @(negedge clk) begin
    if (done2 && !done2_q) begin
      if (q2.size() == 0) begin
        chk("dut2_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("dut2_tt_f1", {24'd0, tt1_2}, {24'd0, e.t1});
        chk("dut2_tt_f2", {24'd0, tt2_2}, {24'd0, e.t2});
        if (e.chk_lat) chk("dut2_latency", cyc, e.cyc);
      end
    end
    done2_q <= done2;
  end

  // Pulse start on dut4 and queue the expected tables and done cycle
  task automatic start_sweep4(input bit expect_done);
    exp_t e;
    @(negedge clk);
    if (expect_done) begin
      e.t1 = 8'h88;
      e.t2 = 8'h3C;
      e.cyc = cyc + 1 + 8 * (D4 + 1);
      e.chk_lat = 1'b1;
      q4.push_back(e);
    end
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic wait_idx4(input logic [2:0] v);
    for (int i = 0; i < 400; i++) begin
      if ({d4, c4, a4} == v) break;
      @(negedge clk);
    end
    chk("dut4_reach_idx", {29'd0, d4, c4, a4}, {29'd0, v});
  endtask

  task automatic wait_done4;
    for (int i = 0; i < 400; i++) begin
      if (done4) break;
      @(negedge clk);
    end
    chk("dut4_done_reached", {31'd0, done4}, 32'd1);
  endtask

  initial begin
    exp_t e;

    // Reset state while rst held
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy4}, 32'd0);
    chk("rst_done", {31'd0, done4}, 32'd0);
    chk("rst_acd", {29'd0, d4, c4, a4}, 32'd0);
    chk("rst_tt_f1", {24'd0, tt1_4}, 32'd0);
    chk("rst_tt_f2", {24'd0, tt2_4}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_after_rst", {30'd0, busy4, done4}, 32'd0);

    // Free-running sweep: latency and tables checked by the monitor
    start_sweep4(1'b1);
    chk("busy_after_start", {30'd0, busy4, done4}, 32'h2);
    wait_done4();
    repeat (6) @(negedge clk);
    chk("done_hold_acd", {29'd0, d4, c4, a4}, 32'd7);
    chk("done_hold_tt_f1", {24'd0, tt1_4}, 32'h88);
    chk("done_hold_flags", {30'd0, busy4, done4}, 32'h1);

    // Restart from DONE; start+step and step during DRIVE must be ignored
    start_sweep4(1'b1);
    chk("restart_tt_f1_clear", {24'd0, tt1_4}, 32'd0);
    chk("restart_tt_f2_clear", {24'd0, tt2_4}, 32'd0);
    chk("restart_flags", {30'd0, busy4, done4}, 32'h2);
    wait_idx4(3'd3);
    start4 = 1'b1;
    step4  = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    step4  = 1'b0;
    chk("ignored_start_idx", {29'd0, d4, c4, a4}, 32'd3);
    wait_idx4(3'd5);
    step4 = 1'b1;
    @(negedge clk);
    step4 = 1'b0;
    chk("ignored_step_idx", {29'd0, d4, c4, a4}, 32'd5);
    wait_done4();
    repeat (2) @(negedge clk);

    // Reset mid-DRIVE at idx 4: outputs clear without waiting for a clock edge
    start_sweep4(1'b0);
    wait_idx4(3'd4);
    chk("pre_rst_tt_f1", {24'd0, tt1_4}, 32'h08);
    rst = 1'b1;
    #1;
    chk("midrst_acd", {29'd0, d4, c4, a4}, 32'd0);
    chk("midrst_flags", {30'd0, busy4, done4}, 32'd0);
    chk("midrst_tt_f1", {24'd0, tt1_4}, 32'd0);
    chk("midrst_tt_f2", {24'd0, tt2_4}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("stay_idle", {27'd0, busy4, done4, d4, c4, a4}, 32'd0);

    // Step mode on the DWELL=2 instance: seven steps needed to reach DONE
    e.t1 = 8'h88;
    e.t2 = 8'h3C;
    e.cyc = 0;
    e.chk_lat = 1'b0;
    q2.push_back(e);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      repeat (8) @(negedge clk);
      chk("wait_acd", {29'd0, d2, c2, a2}, k);
      chk("wait_flags", {30'd0, busy2, done2}, 32'h2);
      repeat (8) @(negedge clk);
      chk("wait_acd_hold", {29'd0, d2, c2, a2}, k);
      step2 = 1'b1;
      start2 = (k == 2);
      @(negedge clk);
      step2 = 1'b0;
      start2 = 1'b0;
    end
    for (int i = 0; i < 50; i++) begin
      if (done2) break;
      @(negedge clk);
    end
    chk("dut2_done_reached", {31'd0, done2}, 32'd1);

    repeat (3) @(negedge clk);
    chk("q4_drained", q4.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
